fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the fetched-instruction buffer entries (fixed at 2 for this revision).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset: synchronous, active-low.
REQ-005 SHALL have port imem_en  output  1  meaning an instruction-memory read request this cycle.
REQ-006 SHALL have port imem_addr  output  32  meaning the byte address of the request.
REQ-007 SHALL have port imem_rdata  input  32  meaning the read data, valid exactly one cycle after imem_en.
REQ-008 SHALL have port out_valid  output  1  meaning an instruction is presented to decode.
REQ-009 SHALL have port out_ready  input  1  meaning decode accepts the instruction.
REQ-010 SHALL have port out_instr  output  32  meaning the instruction word; opcode field [31:27].
REQ-011 SHALL have port out_pc  output  32  meaning the address of out_instr.
REQ-012 SHALL have port out_illegal  output  1  meaning the out_instr opcode is outside the legal set.
REQ-013 SHALL have port redirect_valid  input  1  meaning a taken branch or restart.
REQ-014 SHALL have port redirect_pc  input  32  meaning the new fetch address.
REQ-015 SHALL have port halted  output  1  meaning the FSM is in HALT.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, HALT.
REQ-017 SHALL transition BOOT->RUN unconditionally one cycle after reset release; the first request (RESET_PC) is issued in the first RUN cycle.
REQ-018 SHALL issue a request only in RUN when (FIFO count + in-flight count) < 2, then advance the PC by 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
REQ-019 SHALL write imem_rdata with its PC into the FIFO at the end of the response cycle; out_valid rises no earlier than 2 cycles after the request.
REQ-020 SHALL complete a transfer when out_valid and out_ready are both high; out_instr, out_pc and out_illegal SHALL be held stable while out_valid is high and out_ready is low.
REQ-021 SHALL sustain one transfer per cycle when out_ready is held high (no bubbles after the first).
REQ-022 SHALL flag illegal for opcodes outside {00001,00010,00011,00100,00101,00111,01000,01001,10000,10001,10010,10011,10100,10101}.
REQ-023 SHALL, on transfer of an illegal instruction, enter HALT; in HALT: no requests, FIFO cleared, out_valid low.
REQ-024 SHALL, on redirect_valid in any state except BOOT: clear the FIFO, discard any in-flight response via an epoch bit, load PC = redirect_pc, enter RUN, and request redirect_pc in the next cycle.
REQ-025 SHALL force out_valid low in any cycle redirect_valid is high; no transfer occurs in that cycle.
REQ-026 SHALL give redirect priority over simultaneous illegal transfer, FIFO write and issue.
REQ-027 SHALL ignore redirect_valid in BOOT.
REQ-028 SHALL force redirect_pc[1:0] to zero.

Reset
REQ-029 SHALL, while rst_n is low at a clock edge: FSM=BOOT, PC=RESET_PC, FIFO empty, in-flight=0, epoch=0.
REQ-030 SHALL drive during reset: imem_en=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_illegal=0, halted=0.
REQ-031 SHALL discard any response in flight when reset is asserted mid-operation.

Structure
REQ-032 SHALL take the opcode enumeration, opcode field bounds and the legal-opcode function from the shared processor package, also used by control_unit.
REQ-033 SHALL contain one sub-module, fetch_fifo (2-entry, 64-bit data+PC, with synchronous flush).

Verification
REQ-034 Reset release, out_ready=1, memory word[i]=i -> requests 0x0,0x4,0x8; first out_valid 2 cycles after first request; out_pc 0,4,8 on consecutive cycles.
REQ-035 out_ready=0 for 5 cycles after first out_valid -> at most 2 requests outstanding, out_instr/out_pc stable, no loss on release.
REQ-036 redirect_valid=1, redirect_pc=0x100 with a response in flight -> out_valid low that cycle, next request 0x100, stale word never presented.
REQ-037 Word 0xF800_0000 (opcode 11111) at 0x8 -> out_illegal=1 on transfer, then halted=1, imem_en=0; redirect to 0x0 -> RUN resumes.
REQ-038 RESET_PC=0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-039 rst_n low for 1 cycle mid-stream -> all outputs at reset values, first post-reset out_pc = RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions: opcode field bounds, opcode enumeration and the
// legal-opcode check used by both fetch_unit and control_unit.
package fetch_unit_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 5'b00001,
    OP_SUB  = 5'b00010,
    OP_AND  = 5'b00011,
    OP_OR   = 5'b00100,
    OP_XOR  = 5'b00101,
    OP_SHF  = 5'b00111,
    OP_LD   = 5'b01000,
    OP_ST   = 5'b01001,
    OP_BEQ  = 5'b10000,
    OP_BNE  = 5'b10001,
    OP_BLT  = 5'b10010,
    OP_BGE  = 5'b10011,
    OP_JAL  = 5'b10100,
    OP_JALR = 5'b10101
  } opcode_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic opcode_legal(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHF, OP_LD, OP_ST,
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JAL, OP_JALR: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched {instruction, pc} pairs with synchronous flush.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; only the pointers and
  // count are, and an entry is never read as valid before it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one-cycle-latency memory reads, buffers responses
// and presents them to decode, halting on an illegal opcode until redirected.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_illegal,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]   state;
  logic [31:0]  pc;
  logic         inflight;
  logic [31:0]  inflight_pc;
  logic         inflight_epoch;
  logic         epoch;

  logic [1:0]   fifo_count;
  fetch_entry_t head;
  logic         in_run;
  logic         redirect;
  logic         xfer;
  logic         halt_take;
  logic         issue;
  logic         fifo_push;
  logic         fifo_flush;
  logic [2:0]   occupancy;

  assign in_run   = rst_n && (state == ST_RUN);
  assign redirect = rst_n && redirect_valid && (state != ST_BOOT);

  assign out_valid   = in_run && (fifo_count != 2'd0) && !redirect_valid;
  assign out_instr   = out_valid ? head.instr : 32'h0;
  assign out_pc      = out_valid ? head.pc : 32'h0;
  assign out_illegal = out_valid && !opcode_legal(head.instr[OPC_MSB:OPC_LSB]);
  assign halted      = rst_n && (state == ST_HALT);

  assign xfer      = out_valid && out_ready;
  assign halt_take = xfer && out_illegal;

  // Slots committed after this cycle: buffered + in flight, less the one leaving now.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, xfer};
  assign issue     = in_run && !redirect && !halt_take && (occupancy < 3'(FIFO_DEPTH));

  assign imem_en   = issue;
  assign imem_addr = rst_n ? pc : RESET_PC;

  assign fifo_push  = in_run && inflight && (inflight_epoch == epoch) && !redirect && !halt_take;
  assign fifo_flush = redirect || halt_take;

  // NOTE: reset is synchronous, so it is checked first inside the clocked
  // block and every state register is updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_BOOT;
      pc             <= RESET_PC;
      inflight       <= 1'b0;
      inflight_pc    <= 32'h0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      inflight       <= issue;
      inflight_pc    <= pc;
      inflight_epoch <= epoch;
      if (redirect) begin
        state <= ST_RUN;
        pc    <= redirect_pc & 32'hFFFF_FFFC;
        epoch <= ~epoch;
      end else begin
        case (state)
          ST_BOOT: state <= ST_RUN;
          ST_RUN:  state <= halt_take ? ST_HALT : ST_RUN;
          ST_HALT: state <= ST_HALT;
          default: state <= ST_BOOT;
        endcase
        if (issue) pc <= pc + 32'd4;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (xfer),
    .wdata ('{instr: imem_rdata, pc: inflight_pc}),
    .rdata (head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-accurate directed bench for fetch_unit: a vector table for the main
// stream plus a second instance exercising PC wrap-around from a high RESET_PC.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        out_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_en, out_valid, out_illegal, halted;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;

  logic        w_en, w_valid, w_illegal, w_halted;
  logic [31:0] w_addr, w_instr, w_pc;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_illegal(out_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_en(w_en), .imem_addr(w_addr),
    .imem_rdata(32'h0800_0000), .out_valid(w_valid), .out_ready(1'b1),
    .out_instr(w_instr), .out_pc(w_pc), .out_illegal(w_illegal),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .halted(w_halted)
  );

  // Memory model: legal opcode 00001 with the word index below it; address 0x8
  // returns opcode 11111 once armed.
  logic armed = 1'b0;
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic arm);
    if (arm && a == 32'h8) return 32'hF800_0000;
    return 32'h0800_0000 | {2'b00, a[31:2]};
  endfunction

  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  always @(negedge clk) begin
    pend      <= imem_en;
    pend_addr <= imem_addr;
  end
  always @(posedge clk) imem_rdata <= pend ? mem_word(pend_addr, armed) : 32'hDEAD_BEEF;

  logic [31:0] w_req_q[$];
  logic [31:0] w_xfer_q[$];
  always @(negedge clk) begin
    if (w_en)    w_req_q.push_back(w_addr);
    if (w_valid) w_xfer_q.push_back(w_pc);
  end

  int checks = 0;
  int errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n, ready, redir, arm;
    logic [31:0] redir_pc;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        illegal, halted;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rs, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic arm,
                              input logic en, input logic [31:0] addr,
                              input logic v, input logic [31:0] pc,
                              input logic ill, input logic h);
    vec_t r;
    r.rst_n = rs; r.ready = rdy; r.redir = rv; r.redir_pc = rpc; r.arm = arm;
    r.en = en; r.addr = addr; r.valid = v; r.pc = pc; r.illegal = ill; r.halted = h;
    return r;
  endfunction

  logic [31:0] exp_wrap [3];
  logic [31:0] exp_instr;

  initial begin
    //                    rst rdy rv rpc        arm  en addr          v  pc           ill h
    vecs.push_back(mk(0, 1, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   0, 0)); // BOOT
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h0,   0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h4,   0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h8,   1, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'hC,   1, 32'h4,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h10,  1, 32'h8,   0, 0));
    for (int k = 0; k < 5; k++)                                              // stall
      vecs.push_back(mk(1, 0, 0, 32'h0, 0,   0, 32'h14,  1, 32'hC,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h14,  1, 32'hC,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h18,  1, 32'h10,  0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h1C,  1, 32'h14,  0, 0));
    vecs.push_back(mk(1, 1, 1, 32'h100, 0,   0, 32'h20,  0, 32'h0,   0, 0)); // redirect
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h100, 0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h104, 0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h108, 1, 32'h100, 0, 0));
    vecs.push_back(mk(1, 1, 1, 32'h2,   1,   0, 32'h10C, 0, 32'h0,   0, 0)); // to 0, arm
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h0,   0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h4,   0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h8,   1, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'hC,   1, 32'h4,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   0, 32'h10,  1, 32'h8,   1, 0)); // illegal
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   0, 32'h10,  0, 32'h0,   0, 1));
    vecs.push_back(mk(1, 1, 1, 32'h3,   0,   0, 32'h10,  0, 32'h0,   0, 1)); // leave HALT
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h0,   0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h4,   0, 32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   0, 0)); // mid reset
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   0, 32'h0,   0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h0,   0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h4,   0, 32'h0,   0, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,   0,   1, 32'h8,   1, 32'h0,   0, 0));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n          = vecs[i].rst_n;
      out_ready      = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].redir_pc;
      if (vecs[i].arm) armed = 1'b1;
      @(negedge clk);
      exp_instr = vecs[i].valid ? mem_word(vecs[i].pc, armed) : 32'h0;
      check($sformatf("row%0d imem_en", i),     32'(imem_en),     32'(vecs[i].en));
      check($sformatf("row%0d imem_addr", i),   imem_addr,        vecs[i].addr);
      check($sformatf("row%0d out_valid", i),   32'(out_valid),   32'(vecs[i].valid));
      check($sformatf("row%0d out_pc", i),      out_pc,           vecs[i].valid ? vecs[i].pc : 32'h0);
      check($sformatf("row%0d out_instr", i),   out_instr,        exp_instr);
      check($sformatf("row%0d out_illegal", i), 32'(out_illegal), 32'(vecs[i].illegal));
      check($sformatf("row%0d halted", i),      32'(halted),      32'(vecs[i].halted));
    end

    // Wrap-around instance: its first three requests and first presented pc.
    exp_wrap[0] = 32'hFFFF_FFF8;
    exp_wrap[1] = 32'hFFFF_FFFC;
    exp_wrap[2] = 32'h0000_0000;
    check("wrap request count>=3", 32'(w_req_q.size() >= 3), 32'd1);
    for (int k = 0; k < 3; k++)
      if (k < w_req_q.size()) check($sformatf("wrap req%0d", k), w_req_q[k], exp_wrap[k]);
    check("wrap transfer count>=1", 32'(w_xfer_q.size() >= 1), 32'd1);
    if (w_xfer_q.size() >= 1) check("wrap first out_pc", w_xfer_q[0], 32'hFFFF_FFF8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
